// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C register-file target.
// Holds the protocol state enum, register byte indices, register reset values
// and the register read-mux helper used by the top level.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } state_t;

    // Byte indices; the low byte of each 16-bit register sits at the even index.
    localparam logic [7:0] REG_IN0  = 8'd0;
    localparam logic [7:0] REG_IN1  = 8'd1;
    localparam logic [7:0] REG_OUT0 = 8'd2;
    localparam logic [7:0] REG_OUT1 = 8'd3;
    localparam logic [7:0] REG_POL0 = 8'd4;
    localparam logic [7:0] REG_POL1 = 8'd5;
    localparam logic [7:0] REG_CFG0 = 8'd6;
    localparam logic [7:0] REG_CFG1 = 8'd7;

    localparam logic [15:0] OUT_RST = 16'hFFFF;
    localparam logic [15:0] POL_RST = 16'h0000;
    localparam logic [15:0] CFG_RST = 16'hFFFF;

    // Byte visible at register index idx; unmapped indices read all ones.
    function automatic logic [7:0] reg_read(input logic [7:0]  idx,
                                            input logic [15:0] in_v,
                                            input logic [15:0] out_v,
                                            input logic [15:0] pol_v,
                                            input logic [15:0] cfg_v);
        logic [15:0] inp;
        logic [7:0]  val;
        inp = in_v ^ pol_v;
        case (idx)
            REG_IN0:  val = inp[7:0];
            REG_IN1:  val = inp[15:8];
            REG_OUT0: val = out_v[7:0];
            REG_OUT1: val = out_v[15:8];
            REG_POL0: val = pol_v[7:0];
            REG_POL1: val = pol_v[15:8];
            REG_CFG0: val = cfg_v[7:0];
            REG_CFG1: val = cfg_v[15:8];
            default:  val = 8'hFF;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_regfile_target_bus_sync.sv
// i2c_bus_sync: brings raw SCL/SDA into the clk domain and derives bus events.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   scl_in, sda_in      - raw asynchronous bus lines
//   sda                 - synchronized SDA level
//   scl_rise, scl_fall  - one-cycle strobes on synchronized SCL edges
//   bus_start, bus_stop - one-cycle strobes for START / STOP conditions
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl;
    logic                   scl_q;
    logic                   sda_q;

    // Reset to the idle bus level so no spurious edge appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_q  <= scl;
            sda_q  <= sda;
        end
    end

    assign scl = scl_sr[SYNC_STAGES-1];
    assign sda = sda_sr[SYNC_STAGES-1];

    assign scl_rise  =  scl & ~scl_q;
    assign scl_fall  = ~scl &  scl_q;
    // SDA may only move while SCL is high for START/STOP; require SCL high on
    // both sides of the SDA edge so a data change near an SCL edge is ignored.
    assign bus_start = scl & scl_q &  sda_q & ~sda;
    assign bus_stop  = scl & scl_q & ~sda_q &  sda;

endmodule

// File: rtl/i2c_regfile_target.sv
// i2c_regfile_target: I2C target exposing a 16-bit GPIO-style register file
// (input, output, polarity, config) at 7-bit address ADDR.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   scl_in, sda_in   - raw bus lines
//   sda_oe_n         - open-drain SDA drive (0 pulls low)
//   in               - input pins
//   out, cfg         - output-port and config registers (cfg bit 1 = input)
//   irq_n            - active-low change interrupt on cfg=1 pins
//   busy             - address-matched transaction in progress
import i2c_target_pkg::*;

module i2c_regfile_target #(
    parameter logic [6:0] ADDR        = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_n,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic [15:0] cfg,
    output logic        irq_n,
    output logic        busy
);

    logic        sda_s, scl_rise, scl_fall, bus_start, bus_stop;
    state_t      state, state_nxt;
    logic        sda_oe_nxt, rd_load;
    logic [7:0]  rx, ptr, rd_val;
    logic [6:0]  tx;          // remaining read bits; the MSB is driven at load
    logic [2:0]  bit_cnt;
    logic        full;        // eight bits of the current byte have been clocked
    logic        ptr_pend, dat_pend;
    logic [15:0] pol, in_lat;
    logic        addr_hit;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .bus_start (bus_start),
        .bus_stop  (bus_stop)
    );

    assign addr_hit = (rx[7:1] == ADDR);
    assign rd_val   = reg_read(ptr, in, out, pol, cfg);

    always_comb begin
        state_nxt  = state;
        sda_oe_nxt = sda_oe_n;
        rd_load    = 1'b0;
        if (bus_start) begin
            state_nxt  = ST_ADDR;
            sda_oe_nxt = 1'b1;
        end else if (bus_stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b1;
        end else begin
            case (state)
                ST_ADDR: if (scl_fall && full) begin
                    state_nxt  = ST_ADDR_ACK;
                    sda_oe_nxt = ~addr_hit;
                end
                ST_PTR: if (scl_fall && full) begin
                    state_nxt  = ST_PTR_ACK;
                    sda_oe_nxt = 1'b0;
                end
                ST_WR: if (scl_fall && full) begin
                    state_nxt  = ST_WR_ACK;
                    sda_oe_nxt = 1'b0;
                end
                ST_ADDR_ACK: begin
                    if (!addr_hit) begin
                        state_nxt  = ST_IDLE;
                        sda_oe_nxt = 1'b1;
                    end else if (scl_fall) begin
                        if (rx[0]) begin
                            state_nxt  = ST_RD;
                            rd_load    = 1'b1;
                            sda_oe_nxt = rd_val[7];
                        end else begin
                            state_nxt  = ST_PTR;
                            sda_oe_nxt = 1'b1;
                        end
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                    state_nxt  = ST_WR;
                    sda_oe_nxt = 1'b1;
                end
                ST_RD: if (scl_fall) begin
                    if (full) begin
                        state_nxt  = ST_RD_ACK;
                        sda_oe_nxt = 1'b1;
                    end else begin
                        sda_oe_nxt = tx[6];
                    end
                end
                // rx[0] holds the master's ACK bit sampled on this slot's rise.
                ST_RD_ACK: if (scl_fall) begin
                    if (!rx[0]) begin
                        state_nxt  = ST_RD;
                        rd_load    = 1'b1;
                        sda_oe_nxt = rd_val[7];
                    end else begin
                        state_nxt  = ST_IDLE;
                        sda_oe_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sda_oe_n <= 1'b1;
            rx       <= 8'h00;
            tx       <= 7'h00;
            bit_cnt  <= 3'd0;
            full     <= 1'b0;
            ptr      <= 8'h00;
            ptr_pend <= 1'b0;
            dat_pend <= 1'b0;
            out      <= OUT_RST;
            pol      <= POL_RST;
            cfg      <= CFG_RST;
            in_lat   <= in;
            irq_n    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sda_oe_n <= sda_oe_nxt;
            irq_n    <= ~|((in ^ in_lat) & cfg);
            ptr_pend <= 1'b0;
            dat_pend <= 1'b0;

            // Bit capture; any state change starts a fresh byte.
            if (bus_start || bus_stop || state_nxt != state) begin
                bit_cnt <= 3'd0;
                full    <= 1'b0;
            end else if (scl_rise) begin
                if (state inside {ST_ADDR, ST_PTR, ST_WR, ST_RD_ACK})
                    rx <= {rx[6:0], sda_s};
                if (state inside {ST_ADDR, ST_PTR, ST_WR, ST_RD}) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        full     <= 1'b1;
                        ptr_pend <= (state == ST_PTR);
                        dat_pend <= (state == ST_WR);
                        if (state == ST_RD)
                            ptr[0] <= ~ptr[0];
                    end
                end
            end

            // Byte commit, one cycle after the eighth sample.
            if (ptr_pend)
                ptr <= rx;
            if (dat_pend) begin
                case (ptr)
                    REG_OUT0: out[7:0]  <= rx;
                    REG_OUT1: out[15:8] <= rx;
                    REG_POL0: pol[7:0]  <= rx;
                    REG_POL1: pol[15:8] <= rx;
                    REG_CFG0: cfg[7:0]  <= rx;
                    REG_CFG1: cfg[15:8] <= rx;
                    default: ;
                endcase
                ptr[0] <= ~ptr[0];
            end

            if (rd_load) begin
                tx <= rd_val[6:0];
                if (ptr[7:1] == 7'd0)
                    in_lat <= in;
            end else if (state == ST_RD && scl_fall && !full && !bus_start && !bus_stop) begin
                tx <= {tx[5:0], 1'b0};
            end

            if (bus_stop)
                busy <= 1'b0;
            else if (state == ST_ADDR_ACK)
                busy <= addr_hit;
            else if (state == ST_RD_ACK && state_nxt == ST_IDLE)
                busy <= 1'b0;
        end
    end

endmodule

// File: doc/i2c_regfile_target.md
I2C_REGFILE_TARGET -- requirements
Module: i2c_regfile_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h20, 7-bit target address matched on the bus.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in (minimum 2).
REQ-003 SHALL have port clk, input, 1, sole clock; one clock domain.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port scl_in, input, 1, raw bus SCL (asynchronous).
REQ-006 SHALL have port sda_in, input, 1, raw bus SDA (asynchronous).
REQ-007 SHALL have port sda_oe_n, output, 1, open-drain SDA drive; 0 pulls SDA low, 1 releases.
REQ-008 SHALL have port in, input, 16, input-port pin values.
REQ-009 SHALL have port out, output, 16, output-port register.
REQ-010 SHALL have port cfg, output, 16, config register; bit=1 means pin is an input.
REQ-011 SHALL have port irq_n, output, 1, active-low change interrupt.
REQ-012 SHALL have port busy, output, 1, high from an address-matched START until STOP or NACK.

Function
REQ-013 SHALL map registers by byte index: 0/1 input (read-only, value in^pol), 2/3 output, 4/5 polarity inversion, 6/7 config; low byte is even. Indices 8-255 read 8'hFF and ignore writes.
REQ-014 SHALL detect START on synced SDA falling while synced SCL is high, and STOP on synced SDA rising while SCL is high; both abort any state, and START goes to ADDR.
REQ-015 SHALL sample SDA on the synced SCL rising edge and change sda_oe_n only on the clk cycle after a synced SCL falling edge is detected.
REQ-016 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK; shift MSB first with a 3-bit bit counter.
REQ-017 SHALL ACK in ADDR_ACK only on an address match; a mismatch releases SDA and returns to IDLE. R/W=0 goes to PTR, R/W=1 goes to RD.
REQ-018 SHALL ACK every pointer and write byte; a written byte commits on the clk cycle after the 8th-bit sample.
REQ-019 SHALL advance the pointer after each data byte by toggling ptr[0] only (pair wrap, 3->2, 7->6).
REQ-020 SHALL load the read shift register at the falling edge that ends ADDR_ACK or RD_ACK, snapshotting the current register value.
REQ-021 SHALL, in RD_ACK, continue to RD on master ACK (SDA=0) and go to IDLE on NACK, releasing SDA.
REQ-022 SHALL latch in on each input-register read; irq_n SHALL go low when in differs from the latched value on any bit with cfg=1, and return high when input register 0 or 1 is read or when in returns to the latched value.
REQ-023 SHALL give priority to reset over START/STOP, and START/STOP over a bit-edge event in the same cycle.
REQ-024 SHALL leave the pointer unchanged across a repeated START, so a repeated-START read begins at the written pointer.

Reset
REQ-025 SHALL reset to state IDLE, sda_oe_n=1, out=16'hFFFF, pol=16'h0000, cfg=16'hFFFF, ptr=0, irq_n=1, busy=0, latched input = in.
REQ-026 SHALL, on reset mid-transaction, release SDA on the next cycle and discard any uncommitted byte.

Structure
REQ-027 SHALL place the state enum, register index constants (REG_IN0..REG_CFG1) and reset values in package i2c_target_pkg.
REQ-028 SHALL use one sub-module, i2c_bus_sync, containing the synchronizers and the SCL rise/fall and START/STOP strobes.

Verification
REQ-029 Write 0x20(W), ptr 0x02, data 0x5A, 0xC3 -> four ACKs; out=16'hC35A; pointer ends at 2.
REQ-030 Set in=16'h1234, pol=16'h00FF, then write ptr 0x00, repeated START, read 2 bytes (ACK, NACK) -> bytes 0xCB then 0x12; SDA released after NACK.
REQ-031 Address byte 0x42(W) -> no ACK; out unchanged; busy stays 0.
REQ-032 cfg=FFFF, toggle in[3] -> irq_n low; read register 0 -> irq_n high after the read.
REQ-033 STOP issued after 4 data bits of a write to register 6 -> cfg unchanged; state IDLE; sda_oe_n=1.
REQ-034 Assert reset while driving an ACK -> sda_oe_n=1 next cycle; all registers at reset values.
